// File: rtl/sprite_compositor.sv
// sprite_compositor: composites N_OBJ fixed-size rectangles onto a VGA pixel
// stream with a fixed priority. Object 0 has the highest priority.
// Object attributes are shadowed at each vblank rising edge, so an object
// that moves mid-frame does not tear.
// Per-object overlap is accumulated over a frame and reported at the next latch.
//
// Ports:
//   clk, rst                      pixel clock, asynchronous active-low reset
//   hcount/vcount/hsync/vsync/
//   hblnk/vblnk _in/_out          VGA timing; the outputs are delayed 2 cycles
//   rgb_in / rgb_out              background pixel in, composited pixel out (2 cycles)
//   obj_x_pos, obj_y_pos          packed per-object top-left corner, COORD_W bits each
//   obj_color, obj_en             packed per-object fill colour (12 bits) and enable
//   frame_overlap                 bit i: object i overlapped another object last frame
//   frame_done                    one-cycle pulse on each attribute latch
//
// Optional feature: define SPRITE_OUTLINE_EN to draw a 1-pixel white (12'hFFF)
// border on each object. Priority and overlap detection do not change.
module sprite_compositor #(
   parameter int unsigned N_OBJ   = 4,
   parameter int unsigned OBJ_W   = 40,
   parameter int unsigned OBJ_H   = 40,
   parameter int unsigned COORD_W = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [10:0]                hcount_in,
   input  logic [10:0]                vcount_in,
   input  logic                       hsync_in,
   input  logic                       vsync_in,
   input  logic                       hblnk_in,
   input  logic                       vblnk_in,
   input  logic [11:0]                rgb_in,
   input  logic [N_OBJ*COORD_W-1:0]   obj_x_pos,
   input  logic [N_OBJ*COORD_W-1:0]   obj_y_pos,
   input  logic [N_OBJ*12-1:0]        obj_color,
   input  logic [N_OBJ-1:0]           obj_en,
   output logic [10:0]                hcount_out,
   output logic [10:0]                vcount_out,
   output logic                       hsync_out,
   output logic                       vsync_out,
   output logic                       hblnk_out,
   output logic                       vblnk_out,
   output logic [11:0]                rgb_out,
   output logic [N_OBJ-1:0]           frame_overlap,
   output logic                       frame_done
);

   localparam int unsigned SUM_W = COORD_W + 1;
   localparam int unsigned RGB_W = 12;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
   } timing_t;

   logic                vblnk_q;
   logic                latch_c;
   logic [COORD_W-1:0]  shadow_x     [N_OBJ];
   logic [COORD_W-1:0]  shadow_y     [N_OBJ];
   logic [RGB_W-1:0]    shadow_color [N_OBJ];
   logic [N_OBJ-1:0]    shadow_en;

   logic [SUM_W-1:0]    h_ext_c;
   logic [SUM_W-1:0]    v_ext_c;
   logic [N_OBJ-1:0]    hit_c;
   logic [N_OBJ-1:0]    hit_q;
   timing_t             timing_c;
   timing_t             timing_q;
   logic [RGB_W-1:0]    rgb_q;

   logic [N_OBJ-1:0]    overlap_c;
   logic [N_OBJ-1:0]    others_c;
   logic [N_OBJ-1:0]    overlap_acc;
   logic [RGB_W-1:0]    pix_c;

`ifdef SPRITE_OUTLINE_EN
   logic [N_OBJ-1:0]    edge_c;
   logic [N_OBJ-1:0]    edge_q;
`endif

   // Latch happens on the first cycle of vertical blanking
   assign latch_c = vblnk_in & ~vblnk_q;

   assign h_ext_c = SUM_W'(hcount_in);
   assign v_ext_c = SUM_W'(vcount_in);

   assign timing_c = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                       vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

   // Per-object hit test; the extra sum bit clips objects at the screen edge instead of wrapping
   for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
      logic [SUM_W-1:0] x0;
      logic [SUM_W-1:0] y0;
      logic [SUM_W-1:0] x1;
      logic [SUM_W-1:0] y1;

      assign x0 = SUM_W'(shadow_x[g]);
      assign y0 = SUM_W'(shadow_y[g]);
      assign x1 = x0 + SUM_W'(OBJ_W);
      assign y1 = y0 + SUM_W'(OBJ_H);

      assign hit_c[g] = shadow_en[g] & ~hblnk_in & ~vblnk_in &
                        (h_ext_c >= x0) & (h_ext_c < x1) &
                        (v_ext_c >= y0) & (v_ext_c < y1);

`ifdef SPRITE_OUTLINE_EN
      assign edge_c[g] = (h_ext_c == x0) | (h_ext_c == x1 - SUM_W'(1)) |
                         (v_ext_c == y0) | (v_ext_c == y1 - SUM_W'(1));
`endif
   end

   // Shadow attribute registers, loaded only on the latch cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vblnk_q   <= 1'b0;
         shadow_en <= '0;
         for (int i = 0; i < N_OBJ; i++) begin
            shadow_x[i]     <= '0;
            shadow_y[i]     <= '0;
            shadow_color[i] <= '0;
         end
      end else begin
         vblnk_q <= vblnk_in;
         if (latch_c) begin
            shadow_en <= obj_en;
            for (int i = 0; i < N_OBJ; i++) begin
               shadow_x[i]     <= obj_x_pos[i*COORD_W +: COORD_W];
               shadow_y[i]     <= obj_y_pos[i*COORD_W +: COORD_W];
               shadow_color[i] <= obj_color[i*RGB_W +: RGB_W];
            end
         end
      end
   end

   // Stage 1: register hits alongside the delayed timing and background
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_q    <= '0;
         timing_q <= '0;
         rgb_q    <= '0;
`ifdef SPRITE_OUTLINE_EN
         edge_q   <= '0;
`endif
      end else begin
         hit_q    <= hit_c;
         timing_q <= timing_c;
         rgb_q    <= rgb_in;
`ifdef SPRITE_OUTLINE_EN
         edge_q   <= edge_c;
`endif
      end
   end

   // An object overlaps when it and at least one other enabled object hit the same pixel
   always_comb begin
      overlap_c = '0;
      others_c  = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         others_c     = hit_q;
         others_c[i]  = 1'b0;
         overlap_c[i] = hit_q[i] & (|others_c);
      end
   end

   // Priority select: scan from lowest priority so the lowest hit index wins
   always_comb begin
      pix_c = rgb_q;
      for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
         if (hit_q[i]) begin
`ifdef SPRITE_OUTLINE_EN
            pix_c = edge_q[i] ? 12'hFFF : shadow_color[i];
`else
            pix_c = shadow_color[i];
`endif
         end
      end
      if (timing_q.hblnk | timing_q.vblnk) begin
         pix_c = '0;
      end
   end

   // Stage 2: outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= timing_q.hcount;
         vcount_out <= timing_q.vcount;
         hsync_out  <= timing_q.hsync;
         vsync_out  <= timing_q.vsync;
         hblnk_out  <= timing_q.hblnk;
         vblnk_out  <= timing_q.vblnk;
         rgb_out    <= pix_c;
      end
   end

   // Sticky overlap accumulator, reported and cleared on the latch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overlap_acc   <= '0;
         frame_overlap <= '0;
         frame_done    <= 1'b0;
      end else if (latch_c) begin
         frame_overlap <= overlap_acc;
         overlap_acc   <= '0;
         frame_done    <= 1'b1;
      end else begin
         overlap_acc   <= overlap_acc | overlap_c;
         frame_done    <= 1'b0;
      end
   end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to single-object drawing stages: composites N_OBJ rectangular objects onto the incoming VGA pixel stream in one block.
- Applies a fixed priority among objects and double-buffers object attributes at frame boundaries, so moving objects do not tear.
- Reports per-object overlap with any other object once per frame, for game logic such as hero/mirror contact.
- Sits after the map/pickup stage and before the character overlay in the VGA chain.

Parameters:
N_OBJ, 4, number of objects; index 0 has the highest priority
OBJ_W, 40, object width in pixels
OBJ_H, 40, object height in pixels
COORD_W, 12, width of each object coordinate

Ports:
clk  in  1  pixel clock
rst  in  1  reset, asynchronous, active-low
hcount_in  in  11  horizontal pixel count
vcount_in  in  11  vertical line count
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
hblnk_in  in  1  horizontal blank
vblnk_in  in  1  vertical blank
rgb_in  in  12  background pixel colour
obj_x_pos  in  N_OBJ*COORD_W  left edge of each object; object i at [i*COORD_W +: COORD_W]
obj_y_pos  in  N_OBJ*COORD_W  top edge of each object
obj_color  in  N_OBJ*12  fill colour of each object
obj_en  in  N_OBJ  object enable
hcount_out, vcount_out  out  11  timing delayed 2 cycles
hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  timing delayed 2 cycles
rgb_out  out  12  composited pixel
frame_overlap  out  N_OBJ  bit i = object i overlapped another object in the last completed frame
frame_done  out  1  one-cycle pulse at each frame latch

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0.
  - Shadow attribute registers, the overlap accumulator and both pipeline stages are cleared.
  - Nothing is drawn until the first frame latch, because the shadow enables are 0.
- Frame latch:
  - vblnk_in is registered each cycle. Its rising edge (vblnk_in=1, previous value 0) is the latch cycle.
  - On the latch cycle: obj_x_pos, obj_y_pos, obj_color and obj_en are copied to shadow registers.
  - On the same cycle: frame_overlap takes the accumulator value, the accumulator clears, and frame_done=1 for that cycle only.
  - Attribute inputs are ignored on all other cycles.
- Stage 1 (registered):
  - Per-object hit[i] = shadow_en[i] & !hblnk_in & !vblnk_in & (hcount_in >= x_i) & (hcount_in < x_i+OBJ_W) & (vcount_in >= y_i) & (vcount_in < y_i+OBJ_H).
  - Sums are computed in COORD_W+1 bits, with hcount/vcount zero-extended. There is no wrap-around: objects extending past the screen edge are clipped.
  - Timing signals and rgb_in are delayed by one cycle alongside hit.
- Stage 2 (registered):
  - rgb_out = colour of the lowest-index object with hit set; otherwise the delayed rgb_in.
  - rgb_out = 0 when the delayed hblnk or vblnk is set.
  - Timing signals are delayed by a second cycle.
- Total latency: 2 cycles for all outputs, in lock-step.
- Overlap accumulation:
  - Each cycle, for every i, accumulator[i] is set if hit[i] and at least one other hit[j], j != i, is set.
  - Accumulator bits are sticky until the frame latch.
  - A latch cannot coincide with a hit, because hit is gated by blanking and the last visible hit precedes the vblnk edge by at least one hblnk period. No arbitration is needed.
- Attribute changes mid-frame have no visible effect until the next latch.
- A disabled object never hits and never contributes to overlap, including as the "other" object.
- Identical positions: the lower index is drawn, and both overlap bits are set.
- Reset mid-frame: the pipeline restarts cleanly. The first partial frame shows background only.

Optional Feature:
- Macro: SPRITE_OUTLINE_EN.
- Defined: a hit pixel in the object's first/last column or first/last row (hcount==x, hcount==x+OBJ_W-1, vcount==y, vcount==y+OBJ_H-1) is drawn 12'hFFF instead of obj_color. An edge flag is registered in stage 1 to keep latency at 2. Priority and overlap detection are unchanged.
- Not defined: every hit pixel uses obj_color, and no edge logic is synthesised.

Test Plan:
- Reset held low for 5 cycles, then released with obj_en=4'b0001 at x=100, y=100, colour 12'h0_1_c, driven before the first vblnk: rgb_out equals rgb_in delayed 2 cycles until the first frame_done. The next frame shows 12'h01c for h 100..139, v 100..139 only.
- Latency check: hcount_in=100, v=120, after the latch: rgb_out=12'h01c and hcount_out=100 exactly 2 cycles later. hcount 99 and 140 show background.
- Priority and overlap: obj0 at (200,200) colour F00, obj1 at (220,220) colour 00F.
  - Pixel (230,230) shows F00; pixel (250,250) shows 00F.
  - After the next frame_done, frame_overlap=4'b0011.
- Mid-frame move: obj_x_pos changed from 100 to 300 at line 50 of a frame: the current frame still draws at 100. After the next latch the object draws at 300. frame_overlap stays 0 throughout.
- Edge clipping: obj0 at x=1010, OBJ_W=40 on a 1024-wide screen: columns 1010..1023 are drawn, with no pixels at h 0..25 and no spurious wrap. With SPRITE_OUTLINE_EN defined, (1010,y) shows FFF.
- Async reset asserted mid-line: all outputs read 0 within the same cycle. After release, frame_overlap=0 and frame_done stays low until the next vblnk rising edge.
